trng_entropy_sampler: RTL and testbench
=======================================

// Module: trng_entropy_sampler
// PURPOSE
//  Consumes the single raw bit from the balanced XOR tree (free-running ring-oscillator entropy).
//  Synchronises it, samples at a programmable rate, applies a repetition-count health test
//  and optional von Neumann debiasing, and packs accepted bits into WIDTH-bit words.
//  Words go to the SoC bus/FIFO over a valid/ready handshake.
// PARAMETERS
//  WIDTH       32  output word width in bits (>=2)
//  SAMPLE_DIV  16  clk cycles per sample strobe (>=1)
//  REP_LIMIT   32  consecutive identical raw samples that trip the health test (>=2)
// PORTS
//  clk           in   1      single system clock; all state on rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  enable_i      in   1      sampling enable
//  debias_en_i   in   1      1 = von Neumann debias, 0 = raw bits accepted directly
//  entropy_i     in   1      raw XOR-tree output; asynchronous to clk
//  data_o        out  WIDTH  packed entropy word
//  valid_o       out  1      data_o holds an unread word
//  ready_i       in   1      consumer accepts data_o when valid_o && ready_i
//  health_fail_o out  1      sticky repetition-count failure
//  health_clr_i  in   1      clears health_fail_o
//  overflow_o    out  1      sticky: accepted bit dropped because the pipeline was full; cleared by health_clr_i
// BEHAVIOUR
//  Reset: every flop cleared; data_o=0, valid_o=0, health_fail_o=0, overflow_o=0.
//  - Sync: entropy_i through a 2-flop synchroniser; synchronised bit = s.
//  - Divider: counter 0..SAMPLE_DIV-1 runs only while enable_i=1; strobe when cnt==SAMPLE_DIV-1, then wraps to 0.
//    enable_i=0 forces cnt=0, no strobe.
//  - Health: on each strobe compare s with previous sample; equal -> run++ (saturate at REP_LIMIT), else run=1.
//    run reaching REP_LIMIT sets health_fail_o the next cycle. Set wins over health_clr_i in the same cycle.
//    Health test sees raw samples, independent of debias_en_i.
//  - Debias (debias_en_i=1): pair FSM FIRST/SECOND.
//    FIRST: store s -> SECOND.
//    SECOND: (b0,b1)=01 -> accept 0; 10 -> accept 1; 00/11 -> discard; -> FIRST.
//    debias_en_i=0: every strobe accepts s; FSM held in FIRST.
//  - Accumulator: accepted bit shifts in at LSB (acc <= {acc[WIDTH-2:0],bit}); bit count 0..WIDTH.
//    At count==WIDTH the accumulator is full.
//  - Transfer: in any cycle with full && (!valid_o || ready_i): data_o<=acc, valid_o<=1, count<=0.
//    A handshake and a transfer in the same cycle leave valid_o=1 with the new word (no bubble).
//    Latency: the last bit is accepted at edge N; valid_o rises at edge N+1 if the output is free.
//  - Handshake: valid_o && ready_i -> valid_o<=0 unless a transfer reloads it.
//    data_o stable while valid_o && !ready_i. valid_o never drops without a handshake.
//  - Full pipeline: accumulator full and valid_o && !ready_i -> further accepted bits dropped, overflow_o<=1.
//    The accumulator is not overwritten.
//  - enable_i deassert: divider=0, pair FSM=FIRST, bit count=0 (partial word discarded), run=0.
//    A pending output word and sticky flags are kept.
//  - Toggling debias_en_i mid-word is allowed; the pair FSM is reset to FIRST on any change.
//  - Async reset mid-operation: all state cleared immediately; valid_o=0 regardless of ready_i.
// STRUCTURE
//  - Package trng_pkg: defaults TRNG_WORD_W=32, TRNG_SAMPLE_DIV=16, TRNG_REP_LIMIT=32; typedef enum {VN_FIRST, VN_SECOND}.
//  - Sub-module trng_vn_debias: pair FSM; inputs strobe/bit/en; outputs acc_valid/acc_bit.
//  - The synchroniser uses the shared 2-flop sync cell; everything else is inline.
// TESTING
//  1. Reset: hold reset_n=0 with entropy toggling.
//     -> data_o=0, valid_o=0, health_fail_o=0, overflow_o=0; no strobes.
//  2. debias_en_i=0, SAMPLE_DIV=4, WIDTH=8, raw pattern 1,0,1,1,0,0,1,0 at strobes.
//     -> data_o=8'hB2; valid_o rises 1 cycle after the 8th strobe.
//  3. debias_en_i=1, pairs 01,10,00,11,10 ...
//     -> accepted bits 0,1,1 (00/11 discarded); 8 accepted bits form a word; discard count checked.
//  4. Hold entropy_i=1 for REP_LIMIT=32 strobes.
//     -> health_fail_o=1 after the 32nd strobe.
//     -> health_clr_i pulse clears it; clr in the same cycle as a new trip leaves it 1.
//  5. ready_i=0 with continuous entropy.
//     -> word 1 held stable on data_o; word 2 fills the accumulator; next accepted bit sets overflow_o.
//     -> ready_i=1 for one cycle shows word 2 on the next cycle with valid_o staying 1.
//  6. enable_i dropped after 5 of 8 bits, then re-raised.
//     -> partial word discarded; the next word contains only bits sampled after re-enable.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared defaults and types for the TRNG entropy sampler.
// No logic here; latency and backpressure are defined by the modules that import it.
package trng_pkg;

  localparam int TRNG_WORD_W     = 32;
  localparam int TRNG_SAMPLE_DIV = 16;
  localparam int TRNG_REP_LIMIT  = 32;

  typedef enum logic {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Latency: 2 clk edges; no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trng_vn_debias.sv
// Von Neumann pair debiaser (01 -> 0, 10 -> 1, 00/11 dropped); passes raw bits when en=0.
// Latency: acceptance is combinational on the strobe of the second bit of a pair; no backpressure.
module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic strobe,
  input  logic samp_bit,
  output logic acc_valid,
  output logic acc_bit
);

  vn_state_e state;
  logic      first_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= VN_FIRST;
      first_bit <= 1'b0;
    end else if (clr || !en) begin
      state <= VN_FIRST;
    end else if (strobe) begin
      if (state == VN_FIRST) begin
        first_bit <= samp_bit;
        state     <= VN_SECOND;
      end else begin
        state <= VN_FIRST;
      end
    end
  end

  // The first bit of an unequal pair is exactly the accepted value.
  assign acc_valid = en ? (strobe && !clr && (state == VN_SECOND) && (first_bit != samp_bit))
                        : strobe;
  assign acc_bit   = en ? first_bit : samp_bit;

endmodule

// File: rtl/trng_entropy_sampler.sv
// Samples a synchronised ring-oscillator bit, health-tests it, optionally debiases, packs WIDTH-bit words.
// Latency: word valid one edge after its last bit; ready_i low holds data_o, a full pipeline drops bits and flags overflow.
module trng_entropy_sampler
  import trng_pkg::*;
#(
  parameter int WIDTH      = TRNG_WORD_W,
  parameter int SAMPLE_DIV = TRNG_SAMPLE_DIV,
  parameter int REP_LIMIT  = TRNG_REP_LIMIT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             debias_en_i,
  input  logic             entropy_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             health_fail_o,
  input  logic             health_clr_i,
  output logic             overflow_o
);

  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BCNT_W = $clog2(WIDTH + 1);
  localparam int RUN_W  = $clog2(REP_LIMIT + 1);

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [BCNT_W-1:0] BITS_FULL = BCNT_W'(WIDTH);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(REP_LIMIT);

  logic              s;
  logic [CNT_W-1:0]  div_cnt;
  logic              strobe;
  logic [RUN_W-1:0]  run;
  logic              prev_s;
  logic              debias_q;
  logic              vn_clr;
  logic              acc_valid;
  logic              acc_bit;
  logic [WIDTH-1:0]  acc;
  logic [BCNT_W-1:0] bit_cnt;
  logic              full;
  logic              out_free;
  logic              xfer;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (entropy_i),
    .q       (s)
  );

  assign strobe = enable_i && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!enable_i || strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A zero run means no previous sample since enable, so the first strobe starts a fresh run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run           <= '0;
      prev_s        <= 1'b0;
      health_fail_o <= 1'b0;
    end else begin
      if (!enable_i) begin
        run <= '0;
      end else if (strobe) begin
        prev_s <= s;
        if ((run != '0) && (s == prev_s)) begin
          if (run != RUN_MAX) run <= run + 1'b1;
        end else begin
          run <= RUN_W'(1);
        end
      end
      health_fail_o <= (run == RUN_MAX) || (health_fail_o && !health_clr_i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) debias_q <= 1'b0;
    else          debias_q <= debias_en_i;
  end

  assign vn_clr = !enable_i || (debias_en_i != debias_q);

  trng_vn_debias u_vn (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (vn_clr),
    .en        (debias_en_i),
    .strobe    (strobe),
    .samp_bit  (s),
    .acc_valid (acc_valid),
    .acc_bit   (acc_bit)
  );

  assign full     = (bit_cnt == BITS_FULL);
  assign out_free = !valid_o || ready_i;
  assign xfer     = full && out_free;

  // A bit arriving on the transfer cycle starts the next word instead of being dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      bit_cnt    <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (xfer) begin
        data_o  <= acc;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end

      if (!enable_i) begin
        bit_cnt <= '0;
      end else if (xfer) begin
        bit_cnt <= BCNT_W'(acc_valid);
      end else if (acc_valid && !full) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (acc_valid && (!full || xfer)) begin
        acc <= {acc[WIDTH-2:0], acc_bit};
      end

      overflow_o <= (acc_valid && full && !out_free) || (overflow_o && !health_clr_i);
    end
  end

endmodule

// File: tb/tb_trng_entropy_sampler.sv
// Directed bench for trng_entropy_sampler with WIDTH=8, SAMPLE_DIV=4, REP_LIMIT=32.
// Entropy is changed right after each strobe so the synchroniser settles before the next one.
module tb_trng_entropy_sampler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable_i;
  logic       debias_en_i;
  logic       entropy_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       health_fail_o;
  logic       health_clr_i;
  logic       overflow_o;

  int total = 0;
  int bad   = 0;

  trng_entropy_sampler #(
    .WIDTH      (8),
    .SAMPLE_DIV (4),
    .REP_LIMIT  (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable_i      (enable_i),
    .debias_en_i   (debias_en_i),
    .entropy_i     (entropy_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .health_fail_o (health_fail_o),
    .health_clr_i  (health_clr_i),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_and_tick(input logic b);
    entropy_i = b;
    tick();
  endtask

  task automatic rest();
    repeat (3) tick();
  endtask

  // One full sample period; returns 1 time unit after the strobe edge.
  task automatic sample(input logic b);
    set_and_tick(b);
    rest();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  pat2;
    logic [19:0] pat3;
    logic [7:0]  w1;
    logic [7:0]  w2;
    logic [7:0]  pat6;

    pat2 = 8'b1011_0010;
    pat3 = 20'b01_10_00_11_10_01_01_10_10_01;
    w1   = 8'hCA;
    w2   = 8'h5E;
    pat6 = 8'h34;

    reset_n      = 1'b0;
    enable_i     = 1'b0;
    debias_en_i  = 1'b0;
    entropy_i    = 1'b0;
    ready_i      = 1'b0;
    health_clr_i = 1'b0;

    // Reset with entropy toggling
    for (int i = 0; i < 6; i++) begin
      entropy_i = ~entropy_i;
      tick();
    end
    check("rst_data", data_o, 32'h0);
    check("rst_valid", valid_o, 32'h0);
    check("rst_health", health_fail_o, 32'h0);
    check("rst_overflow", overflow_o, 32'h0);
    reset_n = 1'b1;
    tick();
    tick();

    // Raw packing
    enable_i = 1'b1;
    for (int i = 7; i >= 0; i--) sample(pat2[i]);
    check("raw_latency", valid_o, 32'h0);
    tick();
    check("raw_valid", valid_o, 32'h1);
    check("raw_data", data_o, 32'hB2);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("raw_handshake", valid_o, 32'h0);
    enable_i = 1'b0;
    tick();

    // Von Neumann debias
    debias_en_i = 1'b1;
    tick();
    enable_i = 1'b1;
    for (int i = 19; i >= 2; i--) sample(pat3[i]);
    check("vn_discard", valid_o, 32'h0);
    sample(pat3[1]);
    sample(pat3[0]);
    tick();
    check("vn_valid", valid_o, 32'h1);
    check("vn_data", data_o, 32'h66);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("vn_handshake", valid_o, 32'h0);
    enable_i    = 1'b0;
    debias_en_i = 1'b0;
    tick();
    tick();

    // Repetition-count health test
    ready_i  = 1'b1;
    enable_i = 1'b1;
    repeat (31) sample(1'b1);
    check("hl_31", health_fail_o, 32'h0);
    sample(1'b1);
    check("hl_32_same_cycle", health_fail_o, 32'h0);
    set_and_tick(1'b1);
    check("hl_trip", health_fail_o, 32'h1);
    rest();
    sample(1'b0);
    entropy_i    = 1'b0;
    health_clr_i = 1'b1;
    tick();
    health_clr_i = 1'b0;
    check("hl_clear", health_fail_o, 32'h0);
    rest();
    repeat (30) sample(1'b0);
    check("hl_rearm", health_fail_o, 32'h0);
    entropy_i    = 1'b0;
    health_clr_i = 1'b1;
    tick();
    health_clr_i = 1'b0;
    check("hl_set_wins", health_fail_o, 32'h1);
    rest();
    enable_i = 1'b0;
    tick();
    check("hl_sticky", health_fail_o, 32'h1);
    health_clr_i = 1'b1;
    tick();
    health_clr_i = 1'b0;
    check("hl_clear2", health_fail_o, 32'h0);
    tick();
    tick();
    check("hl_drained", valid_o, 32'h0);
    ready_i = 1'b0;

    // Backpressure and overflow
    enable_i = 1'b1;
    for (int i = 7; i >= 0; i--) sample(w1[i]);
    set_and_tick(w2[7]);
    check("bp_w1_valid", valid_o, 32'h1);
    check("bp_w1_data", data_o, 32'hCA);
    rest();
    for (int i = 6; i >= 0; i--) sample(w2[i]);
    check("bp_hold_valid", valid_o, 32'h1);
    check("bp_hold_data", data_o, 32'hCA);
    check("bp_no_overflow", overflow_o, 32'h0);
    sample(1'b1);
    check("bp_overflow", overflow_o, 32'h1);
    check("bp_still_w1", data_o, 32'hCA);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("bp_w2_valid", valid_o, 32'h1);
    check("bp_w2_data", data_o, 32'h5E);
    enable_i = 1'b0;
    ready_i  = 1'b1;
    tick();
    ready_i = 1'b0;
    check("bp_drain", valid_o, 32'h0);
    health_clr_i = 1'b1;
    tick();
    health_clr_i = 1'b0;
    check("bp_ovf_clear", overflow_o, 32'h0);

    // Enable drop discards a partial word
    enable_i = 1'b1;
    repeat (5) sample(1'b1);
    enable_i = 1'b0;
    tick();
    enable_i = 1'b1;
    for (int i = 7; i >= 0; i--) sample(pat6[i]);
    check("en_partial", valid_o, 32'h0);
    tick();
    check("en_valid", valid_o, 32'h1);
    check("en_data", data_o, 32'h34);

    // Asynchronous reset while a word is pending
    ready_i = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", valid_o, 32'h0);
    check("arst_data", data_o, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
